// File: rtl/md_unit_param_if.sv
// Request/result bundle between the EX-stage issue logic and the multiply/divide unit.
// The master issues pre-decoded ops and the slave returns the architectural HI/LO pair.
interface md_unit_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, cancel,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, cancel,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit holding the architectural HI/LO pair.
// The full result is computed into a shadow pair at acceptance; commit waits out the latency.
module md_unit_param #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic             clk,
    input logic             reset,
    md_unit_param_if.slave  md
);
    localparam int DW      = 2 * WIDTH;
    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] sh_r;
    logic [WIDTH-1:0] sl_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;

    logic [DW-1:0]    acc_s;
    logic [DW-1:0]    shadow_s;
    logic [CNT_W-1:0] load_s;
    logic             multi_s;

    // Full-width product; sign- or zero-extending first makes the truncated result exact.
    function automatic logic [DW-1:0] mul_full(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             is_signed
    );
        logic [DW-1:0] x_ext;
        logic [DW-1:0] y_ext;
        x_ext = {{WIDTH{is_signed & x[WIDTH-1]}}, x};
        y_ext = {{WIDTH{is_signed & y[WIDTH-1]}}, y};
        return x_ext * y_ext;
    endfunction

    // Returns {remainder, quotient}; zero divisor and signed overflow have fixed results.
    function automatic logic [DW-1:0] div_full(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             is_signed
    );
        logic             x_neg;
        logic             y_neg;
        logic [WIDTH-1:0] x_mag;
        logic [WIDTH-1:0] y_mag;
        logic [WIDTH-1:0] q_mag;
        logic [WIDTH-1:0] r_mag;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic [DW-1:0]    res;
        x_neg = is_signed & x[WIDTH-1];
        y_neg = is_signed & y[WIDTH-1];
        x_mag = x_neg ? ('0 - x) : x;
        y_mag = y_neg ? ('0 - y) : y;
        q_mag = '0;
        r_mag = '0;
        q     = '0;
        r     = '0;
        if (y == '0) begin
            res = {x, {WIDTH{1'b1}}};
        end else if (is_signed && (x == MOST_NEG) && (y == {WIDTH{1'b1}})) begin
            res = {{WIDTH{1'b0}}, x};
        end else begin
            q_mag = x_mag / y_mag;
            r_mag = x_mag % y_mag;
            q     = (x_neg ^ y_neg) ? ('0 - q_mag) : q_mag;
            r     = x_neg ? ('0 - r_mag) : r_mag;
            res   = {r, q};
        end
        return res;
    endfunction

    assign acc_s = {hi_r, lo_r};

    // Result, latency and op class of the request currently on the bus.
    always_comb begin
        shadow_s = '0;
        load_s   = MUL_LOAD;
        multi_s  = 1'b0;
        case (md.op)
            OP_MULT: begin
                shadow_s = mul_full(md.a, md.b, 1'b1);
                multi_s  = 1'b1;
            end
            OP_MULTU: begin
                shadow_s = mul_full(md.a, md.b, 1'b0);
                multi_s  = 1'b1;
            end
            OP_DIV: begin
                shadow_s = div_full(md.a, md.b, 1'b1);
                load_s   = DIV_LOAD;
                multi_s  = 1'b1;
            end
            OP_DIVU: begin
                shadow_s = div_full(md.a, md.b, 1'b0);
                load_s   = DIV_LOAD;
                multi_s  = 1'b1;
            end
            OP_MADD: begin
                shadow_s = acc_s + mul_full(md.a, md.b, 1'b1);
                multi_s  = 1'b1;
            end
            OP_MADDU: begin
                shadow_s = acc_s + mul_full(md.a, md.b, 1'b0);
                multi_s  = 1'b1;
            end
            OP_MSUB: begin
                shadow_s = acc_s - mul_full(md.a, md.b, 1'b1);
                multi_s  = 1'b1;
            end
            OP_MSUBU: begin
                shadow_s = acc_s - mul_full(md.a, md.b, 1'b0);
                multi_s  = 1'b1;
            end
            default: begin
                shadow_s = '0;
                load_s   = MUL_LOAD;
                multi_s  = 1'b0;
            end
        endcase
    end

    // Control FSM: acceptance, latency countdown, cancel and commit of HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            sh_r    <= '0;
            sl_r    <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (md.start && !md.cancel) begin
                        if (multi_s) begin
                            {sh_r, sl_r} <= shadow_s;
                            cnt_r        <= load_s;
                            busy_r       <= 1'b1;
                            state_r      <= ST_RUN;
                        end else if (md.op == OP_MTHI) begin
                            hi_r <= md.a;
                        end else if (md.op == OP_MTLO) begin
                            lo_r <= md.a;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    done_r <= 1'b0;
                    if (md.cancel) begin
                        sh_r    <= '0;
                        sl_r    <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        hi_r    <= sh_r;
                        lo_r    <= sl_r;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign md.hi   = hi_r;
    assign md.lo   = lo_r;
    assign md.busy = busy_r;
    assign md.done = done_r;
endmodule

// File: tb/tb_md_unit_param.sv
// Directed bench for md_unit_param: a vector table on a 32-bit instance plus
// hand-written cancel, overlap, back-to-back and async-reset sequences on 32/16-bit instances.
module tb_md_unit_param;
    logic clk = 1'b0;
    logic reset32;
    logic reset16;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    md_unit_param_if #(.WIDTH(32)) bus32();
    md_unit_param_if #(.WIDTH(16)) bus16();

    md_unit_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut32 (
        .clk   (clk),
        .reset (reset32),
        .md    (bus32.slave)
    );

    md_unit_param #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk   (clk),
        .reset (reset16),
        .md    (bus16.slave)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] init_hi;
        logic [31:0] init_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at a falling edge; the request is sampled at the rising edge in between.
    task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic c);
        bus32.start  = 1'b1;
        bus32.op     = op;
        bus32.a      = a;
        bus32.b      = b;
        bus32.cancel = c;
        @(negedge clk);
        bus32.start  = 1'b0;
        bus32.cancel = 1'b0;
    endtask

    task automatic finish32(input int lat, input logic [31:0] eh, input logic [31:0] el, input string tag);
        int cnt;
        int dn;
        cnt = 0;
        dn  = 0;
        while (bus32.busy === 1'b1 && cnt < 200) begin
            cnt++;
            if (bus32.done === 1'b1) dn++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(cnt), 64'(lat));
        check({tag, "_done_in_busy"}, 64'(dn), 64'd0);
        check({tag, "_done"}, 64'(bus32.done), 64'd1);
        check({tag, "_hi"}, 64'(bus32.hi), 64'(eh));
        check({tag, "_lo"}, 64'(bus32.lo), 64'(el));
    endtask

    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] eh, input logic [31:0] el, input string tag);
        issue32(op, a, b, 1'b0);
        finish32(lat, eh, el, tag);
        @(negedge clk);
        check({tag, "_done_drop"}, 64'(bus32.done), 64'd0);
    endtask

    task automatic set_hl32(input logic [31:0] h, input logic [31:0] l, input string tag);
        issue32(4'd8, h, 32'd0, 1'b0);
        check({tag, "_mthi_busy"}, 64'(bus32.busy), 64'd0);
        issue32(4'd9, l, 32'd0, 1'b0);
        check({tag, "_set_hi"}, 64'(bus32.hi), 64'(h));
        check({tag, "_set_lo"}, 64'(bus32.lo), 64'(l));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int dn;

        vecs[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3,        32'd0, 32'd0,  32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{4'd5, 32'hFFFFFFFF, 32'd2,        32'd1, 32'd2,  32'h00000003, 32'h00000000, 5};
        vecs[2]  = '{4'd6, 32'd1,        32'd1,        32'd0, 32'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 5};
        vecs[3]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        32'd0, 32'd0,  32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{4'd3, 32'd7,        32'd0,        32'd0, 32'd0,  32'h00000007, 32'hFFFFFFFF, 10};
        vecs[5]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0,  32'h00000000, 32'h80000000, 10};
        vecs[6]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,  32'hFFFFFFFE, 32'h00000001, 5};
        vecs[7]  = '{4'd4, 32'hFFFFFFFD, 32'd4,        32'd0, 32'd10, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[8]  = '{4'd7, 32'd2,        32'd3,        32'd0, 32'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 5};
        vecs[9]  = '{4'd3, 32'd100,      32'd7,        32'd0, 32'd0,  32'h00000002, 32'h0000000E, 10};
        vecs[10] = '{4'd2, 32'd7,        32'hFFFFFFFE, 32'd0, 32'd0,  32'h00000001, 32'hFFFFFFFD, 10};
        vecs[11] = '{4'd2, 32'hFFFFFFF9, 32'd0,        32'd0, 32'd0,  32'hFFFFFFF9, 32'hFFFFFFFF, 10};
        vecs[12] = '{4'd6, 32'd3,        32'hFFFFFFFE, 32'd1, 32'd0,  32'h00000001, 32'h00000006, 5};

        reset32 = 1'b0;
        reset16 = 1'b0;
        bus32.start = 1'b0; bus32.op = 4'd0; bus32.a = 32'd0; bus32.b = 32'd0; bus32.cancel = 1'b0;
        bus16.start = 1'b0; bus16.op = 4'd0; bus16.a = 16'd0; bus16.b = 16'd0; bus16.cancel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(bus32.hi), 64'd0);
        check("rst_lo", 64'(bus32.lo), 64'd0);
        check("rst_busy", 64'(bus32.busy), 64'd0);
        check("rst_done", 64'(bus32.done), 64'd0);
        reset32 = 1'b1;
        reset16 = 1'b1;
        @(negedge clk);

        // Table of single operations from a known HI/LO starting point.
        for (int i = 0; i < 13; i++) begin
            set_hl32(vecs[i].init_hi, vecs[i].init_lo, $sformatf("v%0d", i));
            run32(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat,
                  vecs[i].exp_hi, vecs[i].exp_lo, $sformatf("v%0d", i));
        end

        // Unassigned op code: nothing happens.
        set_hl32(32'h11, 32'h22, "nop");
        issue32(4'd12, 32'd5, 32'd6, 1'b0);
        check("nop_busy", 64'(bus32.busy), 64'd0);
        @(negedge clk);
        check("nop_done", 64'(bus32.done), 64'd0);
        check("nop_hi", 64'(bus32.hi), 64'h11);
        check("nop_lo", 64'(bus32.lo), 64'h22);

        // Cancel on the 4th busy cycle of a DIVU, then start+cancel on MTHI.
        set_hl32(32'h55, 32'h55, "cx");
        issue32(4'd3, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        check("cx_busy_c4", 64'(bus32.busy), 64'd1);
        bus32.cancel = 1'b1;
        @(negedge clk);
        bus32.cancel = 1'b0;
        check("cx_busy_drop", 64'(bus32.busy), 64'd0);
        dn = 0;
        repeat (12) begin
            if (bus32.done === 1'b1) dn++;
            @(negedge clk);
        end
        check("cx_no_done", 64'(dn), 64'd0);
        check("cx_hi", 64'(bus32.hi), 64'h55);
        check("cx_lo", 64'(bus32.lo), 64'h55);
        issue32(4'd8, 32'd9, 32'd0, 1'b1);
        @(negedge clk);
        check("cx_mthi_dropped", 64'(bus32.hi), 64'h55);
        check("cx_mthi_busy", 64'(bus32.busy), 64'd0);

        // MTLO during MULT busy is ignored; a new MULT in the done cycle is accepted.
        issue32(4'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
        issue32(4'd9, 32'h1234, 32'd0, 1'b0);
        finish32(4, 32'hFFFFFFFF, 32'hFFFFFFFA, "ign");
        issue32(4'd0, 32'd3, 32'd4, 1'b0);
        check("b2b_busy_rise", 64'(bus32.busy), 64'd1);
        check("b2b_done_low", 64'(bus32.done), 64'd0);
        finish32(5, 32'd0, 32'd12, "b2b");
        @(negedge clk);
        check("b2b_done_drop", 64'(bus32.done), 64'd0);

        // Narrow instance: one-cycle MULTU, then async reset in the middle of a DIV.
        bus16.start = 1'b1; bus16.op = 4'd1; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF;
        @(negedge clk);
        bus16.start = 1'b0;
        cnt = 0;
        while (bus16.busy === 1'b1 && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("w16_busy_cycles", 64'(cnt), 64'd1);
        check("w16_done", 64'(bus16.done), 64'd1);
        check("w16_hi", 64'(bus16.hi), 64'hFFFE);
        check("w16_lo", 64'(bus16.lo), 64'h0001);
        @(negedge clk);
        bus16.start = 1'b1; bus16.op = 4'd2; bus16.a = 16'd100; bus16.b = 16'd7;
        @(negedge clk);
        bus16.start = 1'b0;
        @(negedge clk);
        check("w16_div_busy", 64'(bus16.busy), 64'd1);
        #2 reset16 = 1'b0;
        #1;
        check("w16_arst_hi", 64'(bus16.hi), 64'd0);
        check("w16_arst_lo", 64'(bus16.lo), 64'd0);
        check("w16_arst_busy", 64'(bus16.busy), 64'd0);
        check("w16_arst_done", 64'(bus16.done), 64'd0);
        @(negedge clk);
        reset16 = 1'b1;
        dn = 0;
        repeat (5) begin
            if (bus16.done === 1'b1 || bus16.busy === 1'b1) dn++;
            @(negedge clk);
        end
        check("w16_no_commit", 64'(dn), 64'd0);
        check("w16_post_hi", 64'(bus16.hi), 64'd0);
        check("w16_post_lo", 64'(bus16.lo), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/md_unit_param.md
Name: md_unit_param

Overview:
- Parametrised multiply/divide unit for the EX stage; successor to the fixed 32-bit MD unit.
- Holds the architectural HI/LO pair and runs multi-cycle multiply, divide and multiply-accumulate operations.
- Adds configurable width and latencies, MADD/MSUB accumulate modes, a clean abort on exception or interrupt, defined divide-by-zero and overflow results, and a done pulse.
- Takes a pre-decoded op code from the decoder, so it contains no instruction decode.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 8.
- MUL_CYCLES, 5, busy cycles for multiply and MADD/MSUB ops; must be ≥ 1.
- DIV_CYCLES, 10, busy cycles for divide ops; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request: op/a/b are valid this cycle.
- op  in  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; other codes are no-ops.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- cancel  in  1  exception or interrupt in this stage; kills the current request and any in-flight op.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.
- busy  out  1  a multi-cycle op is in flight.
- done  out  1  one-cycle pulse: hi/lo were just committed by a multi-cycle op.

Behaviour:
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, busy=0, done=0, state IDLE, counter 0, shadow registers 0.
  - Reset mid-operation drops the op; no commit and no done.
- States: IDLE, RUN.
- Request acceptance:
  - A request is accepted at a rising edge only if start=1, cancel=0 and state=IDLE.
  - While busy=1, start is ignored. Upstream stalls on busy. No queueing.
- MTHI/MTLO:
  - Single-cycle.
  - On acceptance, hi (resp. lo) ← a at that edge.
  - busy and done stay 0.
- Multi-cycle ops (codes 0-7):
  - At the accepting edge: the result is computed into the 2×WIDTH shadow {sh,sl}, state→RUN, busy←1, counter←LAT−1.
  - LAT is MUL_CYCLES for codes 0,1,4-7 and DIV_CYCLES for codes 2,3.
  - In RUN, each edge with cancel=0: if counter≠0, decrement; else {hi,lo}←{sh,sl}, busy←0, done←1, state→IDLE.
  - busy is therefore high for exactly LAT cycles after the accepting edge.
  - done is high for the single cycle after the commit edge and returns to 0 at the next edge.
- Cancel:
  - cancel=1 at any edge in RUN: state→IDLE, busy←0, shadow discarded, hi/lo unchanged, done stays 0.
  - cancel=1 together with start: request dropped, including MTHI/MTLO.
- Arithmetic (2×WIDTH product, wrap modulo 2^(2·WIDTH)):
  - MULT: signed a×b.
  - MULTU: unsigned a×b.
  - MADD(U): {hi,lo} + product, using hi/lo as they are at the accepting edge.
  - MSUB(U): {hi,lo} − product, same operand timing.
- Divide:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - b=0 (DIV or DIVU): lo = all ones, hi = a.
  - DIV with a = most-negative and b = −1: lo = a, hi = 0.
- Edge ordering: done is never asserted in the same cycle as a new acceptance's busy rise. A start presented in the done cycle is accepted at that cycle's edge.
- Counter width: $clog2(max(MUL_CYCLES,DIV_CYCLES)+1) bits.

Test Plan:
- Reset release, then MULT a=0xFFFFFFFE (−2), b=3 -> busy high for exactly 5 cycles; done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MTHI a=1, MTLO a=2, then MADDU a=0xFFFFFFFF, b=2 -> after 5 busy cycles, hi=0x00000003, lo=0x00000000. Repeat with MSUB a=1, b=1 from hi=0, lo=0 -> hi=lo=0xFFFFFFFF.
- DIV a=−7, b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU a=100, b=7 with hi=lo=0x55, then cancel=1 on the 4th busy cycle -> busy drops next cycle; done never pulses; hi=lo=0x55. Then start+cancel together with MTHI a=9 -> hi stays 0x55.
- During a MULT's busy window, pulse start with MTLO a=0x1234 -> ignored; lo equals the MULT result after done. Start a new MULT in the done cycle -> accepted; busy rises the next cycle.
- Instance with WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3 and reset asserted mid-DIV -> outputs zero immediately (asynchronously). MULTU 0xFFFF×0xFFFF -> busy 1 cycle; hi=0xFFFE, lo=0x0001.
